// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the seven-segment display path.
// BCD_W is the width of one digit. MAX_DIGITS is the widest display supported.
// clog2 sizes counters and indices. anode_off and anode_sel build
// active-low anode patterns. BCD_DISP_CHECK rejects illegal parameters at
// elaboration.

`define BCD_DISP_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package bcd_disp_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    // Ceiling log2 with a minimum of 1, so a 2-entry index still has a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // All anodes off (active-low). Callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] anode_off();
        return '1;
    endfunction

    // Only anode 'idx' on (driven low). All other anodes stay off.
    function automatic logic [MAX_DIGITS-1:0] anode_sel(input int unsigned idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider that counts 0..DIV-1 while enabled.
// Ports:
//   clk, reset (synchronous, active-high), enable (hold count when low).
//   count  - current prescaler value.
//   tick_c - high when enabled at terminal count; the count wraps on this edge.

module refresh_prescaler
    import bcd_disp_pkg::*;
#(
    parameter  int unsigned DIV   = 100000,
    localparam int unsigned CNT_W = clog2(DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tick_c
);

    `BCD_DISP_CHECK(g_chk_div, DIV >= 2, "refresh_prescaler: DIV must be >= 2")

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    assign tick_c = enable && (count == LAST);

    // Count register. It holds while disabled and wraps after LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= tick_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scanner for a NUM_DIGITS seven-segment display.
// The inputs are captured once per frame, so every frame shows one coherent
// value. Each digit slot starts with a blanking window. Leading zeros can be
// suppressed.
// Ports:
//   clk, reset (synchronous, active-high), enable (pause scanning).
//   digits_in   - packed BCD, digit 0 in [3:0]; dp_in - decimal point per digit.
//   ONE_DIGIT   - BCD of the selected digit; dp_out - its decimal point.
//   anode       - active-low one-hot digit enable; digit_sel - selected index.
//   frame_start - one-cycle pulse on the first cycle of a new frame.

module bcd_scan_mux
    import bcd_disp_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS   = 4,
    parameter  int unsigned REFRESH_DIV  = 100000,
    parameter  int unsigned BLANK_CYCLES = 1000,
    parameter  int unsigned LZ_BLANK     = 1,
    localparam int unsigned SEL_W        = clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [BCD_W-1:0]              ONE_DIGIT,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic                          dp_out,
    output logic [SEL_W-1:0]              digit_sel,
    output logic                          frame_start
);

    `BCD_DISP_CHECK(g_chk_digits, (NUM_DIGITS >= 2) && (NUM_DIGITS <= MAX_DIGITS),
                    "bcd_scan_mux: NUM_DIGITS must be 2..8")
    `BCD_DISP_CHECK(g_chk_div, REFRESH_DIV >= 2, "bcd_scan_mux: REFRESH_DIV must be >= 2")
    `BCD_DISP_CHECK(g_chk_blank, BLANK_CYCLES < REFRESH_DIV,
                    "bcd_scan_mux: BLANK_CYCLES must be < REFRESH_DIV")

    localparam int unsigned PC_W = clog2(REFRESH_DIV);
    localparam int unsigned DW   = BCD_W * NUM_DIGITS;

    logic [PC_W-1:0]       pc;
    logic                  pc_tick_c;
    logic [SEL_W-1:0]      idx;
    logic [DW-1:0]         snap_d;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic                  frame_pend;
    logic                  last_digit_c;
    logic                  lit_window_c;
    logic [NUM_DIGITS-1:0] suppress_c;
    logic [NUM_DIGITS-1:0] anode_nxt_c;
    logic [BCD_W-1:0]      cur_digit_c;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (pc),
        .tick_c (pc_tick_c)
    );

    assign last_digit_c = (idx == SEL_W'(NUM_DIGITS - 1));
    assign cur_digit_c  = snap_d[BCD_W * 32'(idx) +: BCD_W];

    // Anodes stay off for the first BLANK_CYCLES of each slot to hide ghosting.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign lit_window_c = 1'b1;
    end else begin : g_blank
        assign lit_window_c = (pc >= PC_W'(BLANK_CYCLES));
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 and any digit with a decimal point are always shown.
    always_comb begin : lz_mask
        logic zero_above;
        zero_above = 1'b1;
        suppress_c = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (snap_d[k*BCD_W +: BCD_W] == BCD_W'(0));
            if ((LZ_BLANK != 0) && (k != 0) && !snap_dp[k]) begin
                suppress_c[k] = zero_above;
            end
        end
    end

    // Next anode pattern.
    always_comb begin
        anode_nxt_c = NUM_DIGITS'(anode_off());
        if (enable && lit_window_c && !suppress_c[idx]) begin
            anode_nxt_c = NUM_DIGITS'(anode_sel(32'(idx)));
        end
    end

    // Scan state, frame snapshot and registered outputs.
    // frame_pend marks the first cycle of a frame. frame_start follows it
    // one cycle later, together with the first digit of the new snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            snap_d      <= '0;
            snap_dp     <= '0;
            frame_pend  <= 1'b0;
            anode       <= NUM_DIGITS'(anode_off());
            ONE_DIGIT   <= '0;
            dp_out      <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_pend <= pc_tick_c && last_digit_c;
            if (pc_tick_c) begin
                idx <= last_digit_c ? '0 : idx + SEL_W'(1);
                if (last_digit_c) begin
                    snap_d  <= digits_in;
                    snap_dp <= dp_in;
                end
            end
            anode       <= anode_nxt_c;
            ONE_DIGIT   <= cur_digit_c;
            dp_out      <= snap_dp[idx];
            digit_sel   <= idx;
            frame_start <= frame_pend && enable;
        end
    end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4 and
// BLANK_CYCLES=1. A second instance runs with leading-zero suppression off.

module tb_bcd_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;

    logic [3:0]  one_digit, anode, one_digit_nl, anode_nl;
    logic        dp_out, frame_start, dp_out_nl, fs_nl;
    logic [1:0]  digit_sel, sel_nl;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_an, exp_an_nl, exp_d;
    logic       exp_dp, exp_fs;

    always #5 clk = ~clk;

    bcd_scan_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .digits_in(digits_in), .dp_in(dp_in),
        .ONE_DIGIT(one_digit), .anode(anode), .dp_out(dp_out),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    bcd_scan_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(0)
    ) dut_nolz (
        .clk(clk), .reset(reset), .enable(enable),
        .digits_in(digits_in), .dp_in(dp_in),
        .ONE_DIGIT(one_digit_nl), .anode(anode_nl), .dp_out(dp_out_nl),
        .digit_sel(sel_nl), .frame_start(fs_nl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait up to 64 cycles for frame_start; return on the sample where it is 1.
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        step();
        while (frame_start !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL %s frame_start timeout: got %b want 1", name, frame_start);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        int s, c, f;
        v = 16'h1234;
        reset = 1'b1; enable = 1'b1; digits_in = v; dp_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({anode, one_digit, digit_sel, dp_out, frame_start} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got an=%b d=%h sel=%0d dp=%b fs=%b want an=1111 d=0 sel=0 dp=0 fs=0",
                         i, anode, one_digit, digit_sel, dp_out, frame_start);
            end
        end
        reset = 1'b0;
        // Frame 0 shows the zero snapshot. Frame 1 shows 1234.
        for (int j = 0; j < 32; j++) begin
            step();
            f = j / 16; s = (j % 16) / 4; c = j % 4;
            exp_d  = (f == 0) ? 4'h0 : v[s*4 +: 4];
            exp_fs = (j == 16);
            if (c == 0)      exp_an = 4'b1111;
            else if (f == 0) exp_an = (s == 0) ? 4'b1110 : 4'b1111;
            else             exp_an = ~(4'b0001 << s);
            checks++;
            if ({anode, digit_sel, one_digit, frame_start} !== {exp_an, 2'(s), exp_d, exp_fs}) begin
                failures++;
                $display("FAIL first_frames j=%0d got an=%b sel=%0d d=%h fs=%b want an=%b sel=%0d d=%h fs=%b",
                         j, anode, digit_sel, one_digit, frame_start, exp_an, s, exp_d, exp_fs);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] v;
        logic [3:0]  supp;
        int s, c;
        v = 16'h0042; supp = 4'b1100;
        digits_in = v; dp_in = 4'b0000;
        wait_frame("lz_flush");
        wait_frame("lz");
        for (int j = 0; j < 16; j++) begin
            if (j > 0) step();
            s = j / 4; c = j % 4;
            exp_d     = v[s*4 +: 4];
            exp_fs    = (j == 0);
            exp_an    = (c == 0 || supp[s]) ? 4'b1111 : ~(4'b0001 << s);
            exp_an_nl = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
            checks++;
            if ({anode, digit_sel, one_digit, dp_out, frame_start} !== {exp_an, 2'(s), exp_d, 1'b0, exp_fs}) begin
                failures++;
                $display("FAIL lz_on j=%0d got an=%b sel=%0d d=%h dp=%b fs=%b want an=%b sel=%0d d=%h dp=0 fs=%b",
                         j, anode, digit_sel, one_digit, dp_out, frame_start, exp_an, s, exp_d, exp_fs);
            end
            checks++;
            if ({anode_nl, sel_nl, one_digit_nl, dp_out_nl, fs_nl} !== {exp_an_nl, 2'(s), exp_d, 1'b0, exp_fs}) begin
                failures++;
                $display("FAIL lz_off j=%0d got an=%b sel=%0d d=%h dp=%b fs=%b want an=%b sel=%0d d=%h dp=0 fs=%b",
                         j, anode_nl, sel_nl, one_digit_nl, dp_out_nl, fs_nl, exp_an_nl, s, exp_d, exp_fs);
            end
        end
    endtask

    task automatic test_dp_keeps_digit();
        logic [3:0] dpv, supp;
        int s, c;
        dpv = 4'b0100; supp = 4'b1010;
        digits_in = 16'h0000; dp_in = dpv;
        wait_frame("dp_flush");
        wait_frame("dp");
        for (int j = 0; j < 16; j++) begin
            if (j > 0) step();
            s = j / 4; c = j % 4;
            exp_dp = dpv[s];
            exp_fs = (j == 0);
            exp_an = (c == 0 || supp[s]) ? 4'b1111 : ~(4'b0001 << s);
            checks++;
            if ({anode, digit_sel, one_digit, dp_out, frame_start} !== {exp_an, 2'(s), 4'h0, exp_dp, exp_fs}) begin
                failures++;
                $display("FAIL dp_keep j=%0d got an=%b sel=%0d d=%h dp=%b fs=%b want an=%b sel=%0d d=0 dp=%b fs=%b",
                         j, anode, digit_sel, one_digit, dp_out, frame_start, exp_an, s, exp_dp, exp_fs);
            end
        end
    endtask

    task automatic test_snapshot_coherence();
        logic [15:0] v_old, v_new, v;
        int s, c;
        v_old = 16'h1234; v_new = 16'h5678;
        digits_in = v_old; dp_in = 4'b0000;
        wait_frame("snap_flush");
        wait_frame("snap");
        for (int j = 1; j < 32; j++) begin
            step();
            s = (j % 16) / 4; c = j % 4;
            v = (j < 16) ? v_old : v_new;
            exp_d  = v[s*4 +: 4];
            exp_fs = (j == 16);
            exp_an = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
            checks++;
            if ({anode, digit_sel, one_digit, frame_start} !== {exp_an, 2'(s), exp_d, exp_fs}) begin
                failures++;
                $display("FAIL snapshot j=%0d got an=%b sel=%0d d=%h fs=%b want an=%b sel=%0d d=%h fs=%b",
                         j, anode, digit_sel, one_digit, frame_start, exp_an, s, exp_d, exp_fs);
            end
            // Change the input while digit 1 is on screen.
            if (j == 4) digits_in = v_new;
        end
    endtask

    task automatic test_enable_pause();
        logic [3:0] post_an [4];
        logic [1:0] post_sel [4];
        logic [3:0] post_d [4];
        int s, c;
        post_an  = '{4'b1011, 4'b1011, 4'b1111, 4'b0111};
        post_sel = '{2'd2, 2'd2, 2'd3, 2'd3};
        post_d   = '{4'h2, 4'h2, 4'h1, 4'h1};
        digits_in = 16'h1234; dp_in = 4'b0000;
        wait_frame("en_flush");
        wait_frame("en");
        for (int j = 1; j < 10; j++) begin
            step();
            s = j / 4; c = j % 4;
            exp_an = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
            checks++;
            if ({anode, digit_sel} !== {exp_an, 2'(s)}) begin
                failures++;
                $display("FAIL en_pre j=%0d got an=%b sel=%0d want an=%b sel=%0d", j, anode, digit_sel, exp_an, s);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({anode, digit_sel, one_digit, frame_start} !== {4'b1111, 2'd2, 4'h2, 1'b0}) begin
                failures++;
                $display("FAIL en_paused cyc=%0d got an=%b sel=%0d d=%h fs=%b want an=1111 sel=2 d=2 fs=0",
                         i, anode, digit_sel, one_digit, frame_start);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({anode, digit_sel, one_digit} !== {post_an[i], post_sel[i], post_d[i]}) begin
                failures++;
                $display("FAIL en_resume cyc=%0d got an=%b sel=%0d d=%h want an=%b sel=%0d d=%h",
                         i, anode, digit_sel, one_digit, post_an[i], post_sel[i], post_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        logic [3:0] r_an [6];
        logic [1:0] r_sel [6];
        r_an  = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        r_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        digits_in = 16'h1234; dp_in = 4'b1000;
        wait_frame("rst_flush");
        wait_frame("rst");
        for (int j = 1; j <= 13; j++) step();
        checks++;
        if ({anode, digit_sel, one_digit, dp_out} !== {4'b0111, 2'd3, 4'h1, 1'b1}) begin
            failures++;
            $display("FAIL rst_pre got an=%b sel=%0d d=%h dp=%b want an=0111 sel=3 d=1 dp=1",
                     anode, digit_sel, one_digit, dp_out);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({anode, one_digit, digit_sel, dp_out, frame_start} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid got an=%b d=%h sel=%0d dp=%b fs=%b want an=1111 d=0 sel=0 dp=0 fs=0",
                     anode, one_digit, digit_sel, dp_out, frame_start);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({anode, digit_sel, one_digit, dp_out, frame_start} !== {r_an[i], r_sel[i], 4'h0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rst_restart cyc=%0d got an=%b sel=%0d d=%h dp=%b fs=%b want an=%b sel=%0d d=0 dp=0 fs=0",
                         i, anode, digit_sel, one_digit, dp_out, frame_start, r_an[i], r_sel[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; digits_in = 16'h0000; dp_in = 4'b0000;
        test_reset();
        test_leading_zero();
        test_dp_keeps_digit();
        test_snapshot_coherence();
        test_enable_pause();
        test_reset_mid_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
